// File: rtl/keyboard_scan_ctrl_pkg.sv
// keyboard_scan_ctrl_pkg
//   Shared constants for the NUMLED/KEYBOARD keypad scanner. It holds the
//   default matrix size, the bit positions of the status/code word fields,
//   the scanner state encodings and a helper that packs the status register
//   into a bus word.
//   No ports (package).
package keyboard_scan_ctrl_pkg;

  localparam int DEVICE_NUM_KB_ROW = 4;
  localparam int DEVICE_NUM_KB_COL = 4;
  localparam int IO_BUS_WIDTH_DATA = 32;

  // Field positions inside the status/code word
  localparam int KB_DATA_PENDING  = 31;
  localparam int KB_DATA_HELD     = 30;
  localparam int KB_DATA_OVERRUN  = 29;
  localparam int KB_DATA_CODE_MSB = 3;
  localparam int KB_DATA_CODE_LSB = 0;

  // Scanner state encodings
  localparam logic [1:0] KB_ST_SCAN     = 2'd0;
  localparam logic [1:0] KB_ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] KB_ST_HOLD     = 2'd2;

  typedef struct packed {
    logic       pending;
    logic       held;
    logic       overrun;
    logic [3:0] code;
  } kb_status_t;

  // Spread the status fields onto their bus bit positions; every other bit is 0
  function automatic logic [IO_BUS_WIDTH_DATA-1:0] kb_pack_word(input kb_status_t s);
    logic [IO_BUS_WIDTH_DATA-1:0] w;
    w = '0;
    w[KB_DATA_PENDING] = s.pending;
    w[KB_DATA_HELD]    = s.held;
    w[KB_DATA_OVERRUN] = s.overrun;
    w[KB_DATA_CODE_MSB:KB_DATA_CODE_LSB] = s.code;
    return w;
  endfunction

endpackage

// File: rtl/keyboard_scan_ctrl_if.sv
// keyboard_scan_ctrl_if
//   Bundle of the keypad-side and IO-bus-side signals of the keypad scanner.
//   col_signal : column returns, active-low, asynchronous (into the scanner)
//   row_en     : row drive, active-low one-hot (out of the scanner)
//   read_ack   : single-cycle bus-read pulse (into the scanner)
//   data       : status/code word (out of the scanner)
//   Modports: master = bus/keypad side, slave = scanner.
interface keyboard_scan_ctrl_if
  import keyboard_scan_ctrl_pkg::*;
#(
  parameter int ROWS = DEVICE_NUM_KB_ROW,
  parameter int COLS = DEVICE_NUM_KB_COL
) ();

  logic [COLS-1:0]              col_signal;
  logic [ROWS-1:0]              row_en;
  logic                         read_ack;
  logic [IO_BUS_WIDTH_DATA-1:0] data;

  modport master (
    output col_signal,
    output read_ack,
    input  row_en,
    input  data
  );

  modport slave (
    input  col_signal,
    input  read_ack,
    output row_en,
    output data
  );

endinterface

// File: rtl/keyboard_scan_ctrl_sync.sv
// sync_2ff
//   Parameterised-width two-flop synchroniser. Both stages reset to all-ones,
//   which matches the idle (pulled-up) level of the keypad columns.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   i_d   : asynchronous input bits
//   o_q   : synchronised output bits (2 cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keyboard_scan_ctrl.sv
// keyboard_scan_ctrl
//   Matrix-keypad scanner. Drives one row at a time, samples the synchronised
//   column returns at the end of each row slot, debounces the first key found,
//   and records it in a 32-bit status/code word (PENDING/HELD/OVERRUN/CODE).
//   A bus read pulse clears PENDING and OVERRUN.
//   clk   : device clock (deviceClk)
//   rst_n : asynchronous active-low reset
//   bus   : keyboard_scan_ctrl_if.slave (col_signal, row_en, read_ack, data)
module keyboard_scan_ctrl
  import keyboard_scan_ctrl_pkg::*;
#(
  parameter int ROWS         = DEVICE_NUM_KB_ROW,
  parameter int COLS         = DEVICE_NUM_KB_COL,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 200000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keyboard_scan_ctrl_if.slave  bus
);

  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYC);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

  logic [COLS-1:0]   w_col_s;
  logic [1:0]        r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [DEB_W-1:0]  r_deb;
  logic [ROW_W-1:0]  r_row;
  logic [ROWS-1:0]   r_row_en;
  logic [COL_W-1:0]  r_col;
  kb_status_t        r_status;

  logic [COL_W-1:0]  w_low_col;
  logic              w_any_low;
  logic [ROW_W-1:0]  w_next_row;
  logic              w_col_bit;
  logic              w_press;
  logic              w_release;

  sync_2ff #(
    .WIDTH (COLS)
  ) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.col_signal),
    .o_q   (w_col_s)
  );

  // Lowest-index low column wins; the loop runs downward so the last hit is the lowest
  always_comb begin
    w_low_col = '0;
    w_any_low = 1'b0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!w_col_s[c]) begin
        w_low_col = COL_W'(c);
        w_any_low = 1'b1;
      end
    end
  end

  assign w_next_row = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
  assign w_col_bit  = w_col_s[r_col];

  assign w_press   = (r_state == KB_ST_DEBOUNCE) && !w_col_bit && (r_deb == DEB_LAST);
  assign w_release = (r_state == KB_ST_HOLD) && w_col_bit && (r_deb == DEB_LAST);

  // Scan / debounce / hold sequencing, row rotation and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= KB_ST_SCAN;
      r_slot   <= '0;
      r_deb    <= '0;
      r_row    <= '0;
      r_row_en <= ~ROWS'(1);
      r_col    <= '0;
    end else begin
      case (r_state)
        KB_ST_SCAN: begin
          if (r_slot == SLOT_LAST) begin
            r_slot <= '0;
            if (w_any_low) begin
              // Keep driving this row so the latched column stays meaningful
              r_col   <= w_low_col;
              r_deb   <= '0;
              r_state <= KB_ST_DEBOUNCE;
            end else begin
              r_row    <= w_next_row;
              r_row_en <= ~(ROWS'(1) << w_next_row);
            end
          end else begin
            r_slot <= r_slot + SLOT_W'(1);
          end
        end

        KB_ST_DEBOUNCE: begin
          if (!w_col_bit) begin
            if (r_deb == DEB_LAST) begin
              r_deb   <= '0;
              r_state <= KB_ST_HOLD;
            end else begin
              r_deb <= r_deb + DEB_W'(1);
            end
          end else begin
            r_state  <= KB_ST_SCAN;
            r_slot   <= '0;
            r_deb    <= '0;
            r_row    <= w_next_row;
            r_row_en <= ~(ROWS'(1) << w_next_row);
          end
        end

        KB_ST_HOLD: begin
          // Counts consecutive released cycles; any bounce back low restarts it
          if (w_col_bit) begin
            if (r_deb == DEB_LAST) begin
              r_state  <= KB_ST_SCAN;
              r_slot   <= '0;
              r_deb    <= '0;
              r_row    <= w_next_row;
              r_row_en <= ~(ROWS'(1) << w_next_row);
            end else begin
              r_deb <= r_deb + DEB_W'(1);
            end
          end else begin
            r_deb <= '0;
          end
        end

        default: begin
          r_state <= KB_ST_SCAN;
          r_slot  <= '0;
          r_deb   <= '0;
        end
      endcase
    end
  end

  // Status word. A press on the same edge as read_ack wins and treats the old word as read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else begin
      if (w_press) begin
        r_status.code    <= 4'(int'(r_row) * COLS + int'(r_col));
        r_status.pending <= 1'b1;
        r_status.overrun <= r_status.pending && !bus.read_ack;
        r_status.held    <= 1'b1;
      end else begin
        if (bus.read_ack) begin
          r_status.pending <= 1'b0;
          r_status.overrun <= 1'b0;
        end
        if (w_release) begin
          r_status.held <= 1'b0;
        end
      end
    end
  end

  assign bus.row_en = r_row_en;
  assign bus.data   = kb_pack_word(r_status);

endmodule
